debug_clk_ctrl: RTL and testbench

DEBUG_CLK_CTRL -- requirements
Module: debug_clk_ctrl

---
 rtl/debug_clk_ctrl_pkg.sv | 16 +
 rtl/debug_clk_ctrl_if.sv | 23 ++
 rtl/debug_clk_ctrl_tick_divider.sv | 35 +++
 rtl/debug_clk_ctrl.sv | 127 ++++++++++++
 tb/tb_debug_clk_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_clk_ctrl_pkg.sv
// Shared types and parameter defaults for the debug clock controller.
// Holds the run-control FSM encoding used by the top and the bench.
package debug_clk_ctrl_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREG_DEF  = 32;
    localparam int DIV_W_DEF = 24;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_e;

endpackage

// File: rtl/debug_clk_ctrl_if.sv
// Register-file debug read port between the clock controller and the CPU.
// master drives the address, slave returns combinational read data.
interface debug_clk_ctrl_if
    import debug_clk_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int AW   = $clog2(NREG_DEF)
);

    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;

    modport master (
        output dbg_addr,
        input  dbg_data
    );

    modport slave (
        input  dbg_addr,
        output dbg_data
    );

endinterface

// File: rtl/debug_clk_ctrl_tick_divider.sv
// Free-running reloadable down-counter producing a one-cycle terminal count.
// A new ratio is only sampled on reload, so mid-period changes never glitch.
module tick_divider
    import debug_clk_ctrl_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_ratio,
    output logic             tc
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Reset to zero so the first tc lands on the first edge after release.
    assign tc = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - DIV_W'(1);
        if (tc) begin
            cnt_d = div_ratio;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/debug_clk_ctrl.sv
// Run/halt/single-step CPU clock-enable generator with register watch.
// Emits registered cpu_en pulses on divider ticks and mirrors one register.
module debug_clk_ctrl
    import debug_clk_ctrl_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREG  = NREG_DEF,
    parameter  int DIV_W = DIV_W_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_ratio,
    input  logic             run,
    input  logic             step,
    input  logic [AW-1:0]    watch_sel,
    debug_clk_ctrl_if.master dbg,
    output logic             cpu_en,
    output logic             clk_out,
    output logic [XLEN-1:0]  watch_val,
    output logic [CNT_W-1:0] tick_count,
    output logic             halted
);

    logic tc;

    state_e state_q;
    state_e state_d;

    logic             step_q;
    logic             step_d;
    logic             step_rise;
    logic             cpu_en_q;
    logic             cpu_en_d;
    logic             clk_out_q;
    logic             clk_out_d;
    logic [CNT_W-1:0] tick_count_q;
    logic [CNT_W-1:0] tick_count_d;
    logic             halted_q;
    logic             halted_d;
    logic [AW-1:0]    dbg_addr_q;
    logic [AW-1:0]    dbg_addr_d;
    logic [XLEN-1:0]  watch_val_q;
    logic [XLEN-1:0]  watch_val_d;

    tick_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .div_ratio (div_ratio),
        .tc        (tc)
    );

    assign step_rise = step & ~step_q;

    // cpu_en_d is the pulse that becomes visible one cycle after tc.
    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        unique case (state_q)
            HALT: begin
                if (run) begin
                    state_d = RUN;
                end else if (step_rise) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                if (!run) begin
                    state_d = HALT;
                end else begin
                    cpu_en_d = tc;
                end
            end
            STEP: begin
                if (tc) begin
                    cpu_en_d = 1'b1;
                    state_d  = HALT;
                end
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_comb begin
        step_d       = step;
        clk_out_d    = clk_out_q ^ cpu_en_d;
        tick_count_d = tick_count_q + CNT_W'(cpu_en_d);
        halted_d     = (state_d == HALT);
        dbg_addr_d   = watch_sel;
        watch_val_d  = dbg.dbg_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HALT;
            step_q       <= 1'b0;
            cpu_en_q     <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_count_q <= '0;
            halted_q     <= 1'b1;
            dbg_addr_q   <= '0;
            watch_val_q  <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            cpu_en_q     <= cpu_en_d;
            clk_out_q    <= clk_out_d;
            tick_count_q <= tick_count_d;
            halted_q     <= halted_d;
            dbg_addr_q   <= dbg_addr_d;
            watch_val_q  <= watch_val_d;
        end
    end

    assign dbg.dbg_addr = dbg_addr_q;
    assign cpu_en       = cpu_en_q;
    assign clk_out      = clk_out_q;
    assign tick_count   = tick_count_q;
    assign halted       = halted_q;
    assign watch_val    = watch_val_q;

endmodule

// File: tb/tb_debug_clk_ctrl.sv
// Directed self-checking bench for debug_clk_ctrl.
// Each task drives one scenario and checks hand-computed expectations.
module tb_debug_clk_ctrl;

    logic        clk;
    logic        rst;
    logic [23:0] div_ratio;
    logic        run;
    logic        step;
    logic [4:0]  watch_sel;
    logic        cpu_en;
    logic        clk_out;
    logic [31:0] watch_val;
    logic [31:0] tick_count;
    logic        halted;

    int checks = 0;
    int errors = 0;

    debug_clk_ctrl_if #(.XLEN(32), .AW(5)) dif ();

    debug_clk_ctrl #(
        .XLEN  (32),
        .NREG  (32),
        .DIV_W (24),
        .CNT_W (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .div_ratio  (div_ratio),
        .run        (run),
        .step       (step),
        .watch_sel  (watch_sel),
        .dbg        (dif),
        .cpu_en     (cpu_en),
        .clk_out    (clk_out),
        .watch_val  (watch_val),
        .tick_count (tick_count),
        .halted     (halted)
    );

    function automatic logic [31:0] rf_model(input logic [4:0] a);
        if (a == 5'd3) return 32'hDEAD_BEEF;
        return 32'h1000_0000 | {27'h0, a};
    endfunction

    always_comb dif.dbg_data = rf_model(dif.dbg_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [23:0] ratio, input logic r);
        rst       = 1'b1;
        div_ratio = ratio;
        run       = r;
        step      = 1'b0;
        watch_sel = 5'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (cpu_en !== 1'b0) begin
            errors++; $display("FAIL reset_cpu_en got %b want 0", cpu_en);
        end
        checks++;
        if (clk_out !== 1'b0) begin
            errors++; $display("FAIL reset_clk_out got %b want 0", clk_out);
        end
        checks++;
        if (tick_count !== 32'd0) begin
            errors++; $display("FAIL reset_tick got %0d want 0", tick_count);
        end
        checks++;
        if (dif.dbg_addr !== 5'd0) begin
            errors++; $display("FAIL reset_dbg_addr got %0d want 0", dif.dbg_addr);
        end
        checks++;
        if (watch_val !== 32'd0) begin
            errors++; $display("FAIL reset_watch got %h want 0", watch_val);
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++; $display("FAIL reset_halted got %b want 1", halted);
        end
    endtask

    task automatic test_run_div3();
        int n = 0;
        int first = 0;
        int last = 0;
        int gap_err = 0;
        int clk_err = 0;
        do_reset(24'd3, 1'b1);
        for (int cyc = 1; cyc <= 40 && n < 5; cyc++) begin
            tick();
            if (cpu_en) begin
                n++;
                if (n == 1) first = cyc;
                else if (cyc - last != 4) gap_err++;
                last = cyc;
                if (clk_out !== n[0]) clk_err++;
            end
        end
        checks++;
        if (n != 5) begin
            errors++; $display("FAIL run_pulses got %0d want 5", n);
        end
        checks++;
        if (first != 5) begin
            errors++; $display("FAIL run_first_pulse got cycle %0d want 5", first);
        end
        checks++;
        if (gap_err != 0) begin
            errors++; $display("FAIL run_gap got %0d bad gaps want 0", gap_err);
        end
        checks++;
        if (clk_err != 0) begin
            errors++; $display("FAIL run_clk_out got %0d bad toggles want 0", clk_err);
        end
        checks++;
        if (tick_count !== 32'd5) begin
            errors++; $display("FAIL run_tick got %0d want 5", tick_count);
        end
        run = 1'b0;
        tick();
        checks++;
        if (halted !== 1'b1 || cpu_en !== 1'b0) begin
            errors++;
            $display("FAIL run_stop got halted=%b cpu_en=%b want 1 0", halted, cpu_en);
        end
    endtask

    task automatic test_step();
        int pulses = 0;
        int at = 0;
        do_reset(24'd9, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            if (cpu_en) pulses++;
        end
        checks++;
        if (pulses != 0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL step_idle got pulses=%0d halted=%b want 0 1", pulses, halted);
        end
        step = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (cpu_en) begin
                pulses++;
                if (at == 0) at = c;
            end
            if (c == 1) begin
                checks++;
                if (halted !== 1'b0) begin
                    errors++; $display("FAIL step_enter got halted=%b want 0", halted);
                end
                step = 1'b0;
            end
            if (c == 2) step = 1'b1;
        end
        step = 1'b0;
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL step_pulses got %0d want 1", pulses);
        end
        checks++;
        if (at < 1 || at > 11) begin
            errors++; $display("FAIL step_latency got cycle %0d want 1..11", at);
        end
        checks++;
        if (halted !== 1'b1) begin
            errors++; $display("FAIL step_halted got %b want 1", halted);
        end
        checks++;
        if (tick_count !== 32'd1) begin
            errors++; $display("FAIL step_tick got %0d want 1", tick_count);
        end
    endtask

    task automatic test_run_step_same();
        int pulses = 0;
        do_reset(24'd2, 1'b0);
        run  = 1'b1;
        step = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (cpu_en) pulses++;
        end
        checks++;
        if (pulses != 3) begin
            errors++; $display("FAIL same_pulses got %0d want 3", pulses);
        end
        checks++;
        if (halted !== 1'b0) begin
            errors++; $display("FAIL same_halted got %b want 0", halted);
        end
        run  = 1'b0;
        step = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_fast_run();
        do_reset(24'd0, 1'b1);
        tick();
        checks++;
        if (cpu_en !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL fast_enter got cpu_en=%b halted=%b want 0 0", cpu_en, halted);
        end
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++;
            if (cpu_en !== 1'b1) begin
                errors++; $display("FAIL fast_en cycle %0d got %b want 1", c, cpu_en);
            end
        end
        checks++;
        if (tick_count !== 32'd6 || clk_out !== 1'b0) begin
            errors++;
            $display("FAIL fast_count got tick=%0d clk_out=%b want 6 0", tick_count, clk_out);
        end
        run = 1'b0;
        tick();
        checks++;
        if (cpu_en !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL fast_stop got cpu_en=%b halted=%b want 0 1", cpu_en, halted);
        end
        tick();
        checks++;
        if (cpu_en !== 1'b0) begin
            errors++; $display("FAIL fast_stop2 got cpu_en=%b want 0", cpu_en);
        end
    endtask

    task automatic test_watch();
        do_reset(24'd5, 1'b0);
        tick();
        tick();
        checks++;
        if (watch_val !== 32'h1000_0000) begin
            errors++; $display("FAIL watch_idle got %h want 10000000", watch_val);
        end
        watch_sel = 5'd3;
        tick();
        checks++;
        if (dif.dbg_addr !== 5'd3) begin
            errors++; $display("FAIL watch_addr got %0d want 3", dif.dbg_addr);
        end
        checks++;
        if (watch_val !== 32'h1000_0000) begin
            errors++; $display("FAIL watch_lat1 got %h want 10000000", watch_val);
        end
        tick();
        checks++;
        if (watch_val !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL watch_val got %h want deadbeef", watch_val);
        end
        watch_sel = 5'd5;
        tick();
        tick();
        checks++;
        if (watch_val !== 32'h1000_0005) begin
            errors++; $display("FAIL watch_val5 got %h want 10000005", watch_val);
        end
    endtask

    task automatic test_async_reset();
        logic seen = 1'b0;
        do_reset(24'd1, 1'b1);
        watch_sel = 5'd7;
        for (int c = 0; c < 8; c++) tick();
        checks++;
        if (tick_count !== 32'd3 || clk_out !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre got tick=%0d clk_out=%b want 3 1", tick_count, clk_out);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (cpu_en !== 1'b0 || clk_out !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL arst_ctl got cpu_en=%b clk_out=%b halted=%b want 0 0 1",
                     cpu_en, clk_out, halted);
        end
        checks++;
        if (tick_count !== 32'd0 || dif.dbg_addr !== 5'd0 || watch_val !== 32'd0) begin
            errors++;
            $display("FAIL arst_data got tick=%0d addr=%0d watch=%h want 0 0 0",
                     tick_count, dif.dbg_addr, watch_val);
        end
        tick();
        tick();
        checks++;
        if (cpu_en !== 1'b0 || tick_count !== 32'd0) begin
            errors++;
            $display("FAIL arst_hold got cpu_en=%b tick=%0d want 0 0", cpu_en, tick_count);
        end
        @(negedge clk);
        run = 1'b0;
        rst = 1'b0;
        force dut.tick_count_q = 32'hFFFF_FFFF;
        tick();
        @(negedge clk);
        release dut.tick_count_q;
        tick();
        checks++;
        if (tick_count !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL wrap_preset got %h want ffffffff", tick_count);
        end
        step = 1'b1;
        for (int c = 0; c < 8 && !seen; c++) begin
            tick();
            if (cpu_en) seen = 1'b1;
        end
        step = 1'b0;
        checks++;
        if (seen !== 1'b1) begin
            errors++; $display("FAIL wrap_pulse got %b want 1", seen);
        end
        checks++;
        if (tick_count !== 32'd0) begin
            errors++; $display("FAIL wrap_tick got %h want 0", tick_count);
        end
    endtask

    initial begin
        rst       = 1'b1;
        div_ratio = 24'd0;
        run       = 1'b0;
        step      = 1'b0;
        watch_sel = 5'd0;
        test_reset();
        test_run_div3();
        test_step();
        test_run_step_same();
        test_fast_run();
        test_watch();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
